// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a return-address stack.
//
// Executes one operation per rising CLK edge when op_valid=1 and stall=0:
// HOLD, INC, LOAD, BRANCH (signed relative), CALL (push return address and
// jump), RET (pop and jump), CLEAR (back to RESET_VEC, empty stack, clear
// error flags). Code 111 is reserved and behaves as HOLD. All arithmetic on
// the PC wraps modulo 2^ADDR_W.
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   RST_N        synchronous active-low reset
//   op_valid     qualifies op
//   op[2:0]      operation code
//   stall        blocks execution and holds all state (wins over op_valid)
//   in_address   absolute target for LOAD / CALL
//   offset       signed two's-complement offset for BRANCH
//   out_address  registered current PC
//   sp           stack occupancy, 0..STACK_DEPTH
//   stack_empty  sp == 0
//   stack_full   sp == STACK_DEPTH
//   err_ovf      sticky: CALL attempted on a full stack
//   err_unf      sticky: RET attempted on an empty stack
module pc_sequencer #(
  parameter int                 ADDR_W      = 19,
  parameter int                 OFF_W       = 9,
  parameter int                 STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0]  RESET_VEC   = '0
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic                               op_valid,
  input  logic [2:0]                         op,
  input  logic                               stall,
  input  logic [ADDR_W-1:0]                  in_address,
  input  logic [OFF_W-1:0]                   offset,
  output logic [ADDR_W-1:0]                  out_address,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               stack_empty,
  output logic                               stack_full,
  output logic                               err_ovf,
  output logic                               err_unf
);

  localparam int SP_W  = $clog2(STACK_DEPTH+1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_INC    = 3'b001,
    OP_LOAD   = 3'b010,
    OP_BRANCH = 3'b011,
    OP_CALL   = 3'b100,
    OP_RET    = 3'b101,
    OP_CLEAR  = 3'b110,
    OP_RSVD   = 3'b111
  } op_e;

  // Wrapping increment; the carry out of the top bit is simply dropped.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

  // Relative branch: sign-extend the offset to the PC width, then add with
  // natural wraparound so negative offsets below 0 land near the top.
  function automatic logic [ADDR_W-1:0] pc_branch(
    input logic [ADDR_W-1:0]        pc,
    input logic signed [OFF_W-1:0]  off
  );
    logic signed [ADDR_W-1:0] off_ext;
    off_ext = ADDR_W'(off);
    return pc + $unsigned(off_ext);
  endfunction

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  logic              exec;
  op_e               op_dec;
  logic [ADDR_W-1:0] pc_nxt;
  logic [SP_W-1:0]   sp_nxt;
  logic              ovf_nxt;
  logic              unf_nxt;
  logic              push;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [ADDR_W-1:0] ret_addr;

  assign exec        = op_valid & ~stall;
  assign op_dec      = op_e'(op);
  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  // sp is below STACK_DEPTH whenever a push happens and above 0 whenever a
  // pop happens, so both indices stay inside the storage.
  assign wr_idx      = sp[IDX_W-1:0];
  assign rd_idx      = IDX_W'(sp - SP_W'(1));
  assign ret_addr    = pc_inc(out_address);

  always_comb begin
    pc_nxt  = out_address;
    sp_nxt  = sp;
    ovf_nxt = err_ovf;
    unf_nxt = err_unf;
    push    = 1'b0;
    if (exec) begin
      unique case (op_dec)
        OP_INC:    pc_nxt = pc_inc(out_address);
        OP_LOAD:   pc_nxt = in_address;
        OP_BRANCH: pc_nxt = pc_branch(out_address, $signed(offset));
        OP_CALL: begin
          if (stack_full) begin
            ovf_nxt = 1'b1;
          end else begin
            push   = 1'b1;
            sp_nxt = sp + SP_W'(1);
            pc_nxt = in_address;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            unf_nxt = 1'b1;
          end else begin
            sp_nxt = sp - SP_W'(1);
            pc_nxt = stack_mem[rd_idx];
          end
        end
        OP_CLEAR: begin
          pc_nxt  = RESET_VEC;
          sp_nxt  = '0;
          ovf_nxt = 1'b0;
          unf_nxt = 1'b0;
        end
        OP_HOLD, OP_RSVD: ;
        default: ;
      endcase
    end
  end

  // Register stage: PC, stack pointer and sticky flags
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_address <= RESET_VEC;
      sp          <= '0;
      err_ovf     <= 1'b0;
      err_unf     <= 1'b0;
    end else begin
      out_address <= pc_nxt;
      sp          <= sp_nxt;
      err_ovf     <= ovf_nxt;
      err_unf     <= unf_nxt;
    end
  end

  // Stack storage carries no reset; a push coinciding with reset is dropped
  // so a reset CALL leaves no trace.
  always_ff @(posedge CLK) begin
    if (RST_N && push) begin
      stack_mem[wr_idx] <= ret_addr;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int    ADDR_W = 19;
  localparam int    OFF_W  = 9;
  localparam int    DEPTH  = 8;
  localparam longint MOD   = 64'd1 << ADDR_W;
  localparam longint RV    = 0;

  localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, LOAD = 3'd2, BRANCH = 3'd3,
                         CALL = 3'd4, RET = 3'd5, CLEAR = 3'd6, RSVD = 3'd7;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              op_valid;
  logic [2:0]        op;
  logic              stall;
  logic [ADDR_W-1:0] in_address;
  logic [OFF_W-1:0]  offset;
  logic [ADDR_W-1:0] out_address;
  logic [3:0]        sp;
  logic              stack_empty;
  logic              stack_full;
  logic              err_ovf;
  logic              err_unf;

  pc_sequencer #(
    .ADDR_W(ADDR_W), .OFF_W(OFF_W), .STACK_DEPTH(DEPTH), .RESET_VEC('0)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .op_valid(op_valid), .op(op), .stall(stall),
    .in_address(in_address), .offset(offset), .out_address(out_address),
    .sp(sp), .stack_empty(stack_empty), .stack_full(stack_full),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 CLK = ~CLK;

  // Behavioural reference: PC as an integer, stack as a queue.
  longint m_pc;
  longint m_stk[$];
  bit     m_ovf;
  bit     m_unf;
  int     n_cmp;
  int     n_fail;

  logic [26:0] dut_vec;
  assign dut_vec = {out_address, sp, stack_empty, stack_full, err_ovf, err_unf};

  function automatic logic [26:0] exp_vec();
    logic [ADDR_W-1:0] p;
    int n;
    p = ADDR_W'(m_pc);
    n = m_stk.size();
    return {p, 4'(n), n == 0, n == DEPTH, m_ovf, m_unf};
  endfunction

  function automatic void model(input bit rstn, input bit v, input bit st,
                                input logic [2:0] o, input longint a, input int f);
    int fo;
    if (!rstn) begin
      m_pc = RV; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (v && !st) begin
      case (o)
        INC:    m_pc = (m_pc + 1) % MOD;
        LOAD:   m_pc = a % MOD;
        BRANCH: begin
          fo = f & 511;
          if (fo >= 256) fo = fo - 512;
          m_pc = (m_pc + fo + MOD) % MOD;
        end
        CALL: begin
          if (m_stk.size() < DEPTH) begin
            m_stk.push_back((m_pc + 1) % MOD);
            m_pc = a % MOD;
          end else m_ovf = 1;
        end
        RET: begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else m_unf = 1;
        end
        CLEAR: begin
          m_pc = RV; m_stk.delete(); m_ovf = 0; m_unf = 0;
        end
        default: ;
      endcase
    end
  endfunction

  // Drive one cycle away from the edge, let the edge happen, update the model.
  task automatic step(input bit rstn, input bit v, input bit st,
                      input logic [2:0] o, input longint a, input int f);
    RST_N      = rstn;
    op_valid   = v;
    stall      = st;
    op         = o;
    in_address = ADDR_W'(a);
    offset     = OFF_W'(f);
    @(posedge CLK);
    #1;
    model(rstn, v, st, o, a, f);
  endtask

  task automatic test_reset();
    step(0, 1, 0, CALL, 19'h1234, 0);
    step(0, 1, 0, INC, 0, 0);
    n_cmp++;
    if (out_address !== 19'h0 || sp !== 4'd0 || stack_empty !== 1'b1 ||
        stack_full !== 1'b0 || err_ovf !== 1'b0 || err_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got pc=%h sp=%0d e=%b f=%b ovf=%b unf=%b, want pc=0 sp=0 e=1 f=0 flags 0",
               out_address, sp, stack_empty, stack_full, err_ovf, err_unf);
    end
  endtask

  task automatic test_inc();
    for (int i = 1; i <= 5; i++) begin
      step(1, 1, 0, INC, 0, 0);
      n_cmp++;
      if (out_address !== ADDR_W'(i) || sp !== 4'd0 || stack_empty !== 1'b1) begin
        n_fail++;
        $display("FAIL inc_%0d: got pc=%h sp=%0d e=%b, want pc=%h sp=0 e=1",
                 i, out_address, sp, stack_empty, i);
      end
    end
  endtask

  task automatic test_wrap();
    step(1, 1, 0, LOAD, 19'h7FFFF, 0);
    n_cmp++;
    if (out_address !== 19'h7FFFF) begin
      n_fail++; $display("FAIL load_max: got %h want 7ffff", out_address);
    end
    step(1, 1, 0, INC, 0, 0);
    n_cmp++;
    if (out_address !== 19'h00000) begin
      n_fail++; $display("FAIL inc_wrap: got %h want 00000", out_address);
    end
    step(1, 1, 0, BRANCH, 0, 9'h1FF);
    n_cmp++;
    if (out_address !== 19'h7FFFF) begin
      n_fail++; $display("FAIL branch_neg_wrap: got %h want 7ffff", out_address);
    end
    step(1, 1, 0, BRANCH, 0, 9'h0FF);
    n_cmp++;
    if (out_address !== 19'h000FE) begin
      n_fail++; $display("FAIL branch_pos_wrap: got %h want 000fe", out_address);
    end
    step(1, 1, 0, BRANCH, 0, 9'h100);
    n_cmp++;
    if (out_address !== 19'h7FFFE) begin
      n_fail++; $display("FAIL branch_min: got %h want 7fffe", out_address);
    end
  endtask

  task automatic test_call_ret();
    logic [ADDR_W-1:0] want_pc [4];
    logic [3:0]        want_sp [4];
    logic [2:0]        ops     [4];
    longint            tgt     [4];
    want_pc = '{19'h200, 19'h300, 19'h201, 19'h101};
    want_sp = '{4'd1, 4'd2, 4'd1, 4'd0};
    ops     = '{CALL, CALL, RET, RET};
    tgt     = '{64'h200, 64'h300, 64'h0, 64'h0};
    step(1, 1, 0, LOAD, 19'h100, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, ops[i], tgt[i], 0);
      n_cmp++;
      if (out_address !== want_pc[i] || sp !== want_sp[i] || err_ovf !== 1'b0 || err_unf !== 1'b0) begin
        n_fail++;
        $display("FAIL call_ret_%0d: got pc=%h sp=%0d ovf=%b unf=%b, want pc=%h sp=%0d flags 0",
                 i, out_address, sp, err_ovf, err_unf, want_pc[i], want_sp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    step(1, 1, 0, CLEAR, 0, 0);
    for (int i = 1; i <= 8; i++) step(1, 1, 0, CALL, 64'h10 * i, 0);
    n_cmp++;
    if (sp !== 4'd8 || stack_full !== 1'b1 || out_address !== 19'h80 || err_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL fill: got sp=%0d full=%b pc=%h ovf=%b, want sp=8 full=1 pc=80 ovf=0",
               sp, stack_full, out_address, err_ovf);
    end
    step(1, 1, 0, CALL, 19'h90, 0);
    n_cmp++;
    if (sp !== 4'd8 || out_address !== 19'h80 || err_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_call: got sp=%0d pc=%h ovf=%b, want sp=8 pc=80 ovf=1", sp, out_address, err_ovf);
    end
    step(1, 1, 0, INC, 0, 0);
    n_cmp++;
    if (out_address !== 19'h81 || err_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got pc=%h ovf=%b, want pc=81 ovf=1", out_address, err_ovf);
    end
    step(1, 1, 0, RET, 0, 0);
    n_cmp++;
    if (out_address !== 19'h71 || sp !== 4'd7 || err_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ret_after_ovf: got pc=%h sp=%0d ovf=%b, want pc=71 sp=7 ovf=1", out_address, sp, err_ovf);
    end
    step(1, 1, 0, CLEAR, 0, 0);
    n_cmp++;
    if (out_address !== 19'h0 || sp !== 4'd0 || err_ovf !== 1'b0 || err_unf !== 1'b0 || stack_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL clear: got pc=%h sp=%0d ovf=%b unf=%b, want pc=0 sp=0 flags 0",
               out_address, sp, err_ovf, err_unf);
    end
  endtask

  task automatic test_underflow_stall();
    step(1, 1, 0, LOAD, 19'h33, 0);
    step(1, 1, 0, RET, 0, 0);
    n_cmp++;
    if (out_address !== 19'h33 || sp !== 4'd0 || err_unf !== 1'b1) begin
      n_fail++;
      $display("FAIL unf: got pc=%h sp=%0d unf=%b, want pc=33 sp=0 unf=1", out_address, sp, err_unf);
    end
    step(1, 0, 0, LOAD, 19'h55, 0);
    n_cmp++;
    if (out_address !== 19'h33 || err_unf !== 1'b1) begin
      n_fail++; $display("FAIL invalid_load: got pc=%h unf=%b, want pc=33 unf=1", out_address, err_unf);
    end
    step(1, 1, 1, LOAD, 19'h55, 0);
    n_cmp++;
    if (out_address !== 19'h33) begin
      n_fail++; $display("FAIL stall_load: got pc=%h want 33", out_address);
    end
    step(1, 1, 1, CALL, 19'h66, 0);
    n_cmp++;
    if (out_address !== 19'h33 || sp !== 4'd0) begin
      n_fail++; $display("FAIL stall_call: got pc=%h sp=%0d, want pc=33 sp=0", out_address, sp);
    end
    step(1, 1, 0, RSVD, 19'h77, 0);
    n_cmp++;
    if (out_address !== 19'h33 || sp !== 4'd0) begin
      n_fail++; $display("FAIL reserved_op: got pc=%h sp=%0d, want pc=33 sp=0", out_address, sp);
    end
  endtask

  task automatic test_reset_during_call();
    step(1, 1, 0, LOAD, 19'h123, 0);
    step(1, 1, 0, CALL, 19'h20, 0);
    step(1, 1, 0, RET, 0, 0);
    step(1, 1, 0, RET, 0, 0);
    step(0, 1, 0, CALL, 19'h40, 0);
    n_cmp++;
    if (out_address !== 19'h0 || sp !== 4'd0 || err_ovf !== 1'b0 || err_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_call: got pc=%h sp=%0d ovf=%b unf=%b, want pc=0 sp=0 flags 0",
               out_address, sp, err_ovf, err_unf);
    end
    // A reset pulse that ends before the edge must not be seen.
    RST_N = 1'b1; op_valid = 1'b1; stall = 1'b0; op = LOAD; in_address = 19'h2AB;
    #2 RST_N = 1'b0;
    #2 RST_N = 1'b1;
    @(posedge CLK);
    #1;
    model(1, 1, 0, LOAD, 64'h2AB, 0);
    n_cmp++;
    if (out_address !== 19'h2AB) begin
      n_fail++; $display("FAIL glitch_reset: got pc=%h want 2ab", out_address);
    end
    step(1, 1, 0, CALL, 19'h500, 0);
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL post_reset_call: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    bit         r, v, s;
    logic [2:0] o;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) != 0);
      v = ($urandom_range(0, 9) < 8);
      s = ($urandom_range(0, 9) < 2);
      o = 3'($urandom_range(0, 7));
      if (o == CLEAR && $urandom_range(0, 3) != 0) o = CALL;
      step(r, v, s, o, longint'($urandom_range(0, 32'h7FFFF)), int'($urandom_range(0, 511)));
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_%0d: op=%0d v=%b s=%b r=%b got {pc,sp,e,f,o,u}=%h want %h",
                 i, o, v, s, r, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1, 1, 0, CLEAR, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 0, ($urandom_range(0, 1) == 0) ? CALL : RET,
           longint'($urandom_range(0, 32'h7FFFF)), 0);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b_%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    m_pc = RV; m_ovf = 0; m_unf = 0;
    RST_N = 1'b0; op_valid = 1'b0; stall = 1'b0; op = HOLD;
    in_address = '0; offset = '0;
    test_reset();
    test_inc();
    test_wrap();
    test_call_ret();
    test_overflow();
    test_underflow_stall();
    test_reset_during_call();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
